// File: rtl/dtree_infer_sched_if.sv
// Stream bundle for dtree_infer_sched: sample input stream (s_*) and
// classified result stream (m_*). The slave modport is the scheduler's view;
// the master modport is the view of whoever feeds samples and takes results.
interface dtree_infer_sched_if #(
   parameter int FEAT_W  = 8,
   parameter int CLASS_W = 2,
   parameter int TAG_W   = 8
);
   logic               s_valid;
   logic               s_ready;
   logic [FEAT_W-1:0]  s_feat;
   logic               m_valid;
   logic               m_ready;
   logic [CLASS_W-1:0] m_class;
   logic [TAG_W-1:0]   m_tag;

   modport slave (
      input  s_valid, s_feat, m_ready,
      output s_ready, m_valid, m_class, m_tag
   );

   modport master (
      output s_valid, s_feat, m_ready,
      input  s_ready, m_valid, m_class, m_tag
   );
endinterface

// File: rtl/dtree_infer_sched.sv
// dtree_infer_sched: sequencing controller in front of a slow combinational
// decision-tree classifier. Samples are buffered in a small FIFO, driven one
// at a time onto clf_feat, held for SETTLE cycles, and the resulting class is
// returned on the m_* stream with a wrapping sequence tag.
// Optional feature: define DTREE_HIST_EN to add saturating per-class result
// counters readable through hist_sel/hist_count (cleared by hist_clr).
module dtree_infer_sched #(
   parameter int FEAT_W     = 8,
   parameter int CLASS_W    = 2,
   parameter int SETTLE     = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 8,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   dtree_infer_sched_if.slave  bus,
   output logic [FEAT_W-1:0]   clf_feat,
   input  logic [CLASS_W-1:0]  clf_class,
   output logic                busy,
   input  logic [CLASS_W-1:0]  hist_sel,
   input  logic                hist_clr,
   output logic [CNT_W-1:0]    hist_count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_OUT    = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [FEAT_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W:0]      r_count;
   logic [7:0]          r_settle_cnt;
   logic [FEAT_W-1:0]   r_clf_feat;
   logic                r_m_valid;
   logic [CLASS_W-1:0]  r_m_class;
   logic [TAG_W-1:0]    r_m_tag;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_hs;
   logic                w_capture;

   // No pass-through when full: a pop in the same cycle does not free a slot
   // for the incoming sample, so s_ready depends only on the stored count.
   assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = bus.s_valid && !w_full;
   assign w_hs    = r_m_valid && bus.m_ready;

   assign bus.s_ready = !w_full;
   assign bus.m_valid = r_m_valid;
   assign bus.m_class = r_m_class;
   assign bus.m_tag   = r_m_tag;
   assign clf_feat    = r_clf_feat;

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode.
   // NOTE: the default assignment up front keeps every path assigned, so no
   // latch is inferred when a case arm leaves the signal untouched.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (!w_empty) w_state_nxt = ST_SETTLE;
         ST_SETTLE: if (r_settle_cnt == '0) w_state_nxt = ST_OUT;
         ST_OUT:    if (w_hs) w_state_nxt = w_empty ? ST_IDLE : ST_SETTLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // State-derived controls: FIFO pop, class capture and busy.
   always_comb begin
      w_pop     = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         ST_IDLE:   w_pop     = !w_empty;
         ST_SETTLE: w_capture = (r_settle_cnt == '0);
         ST_OUT:    w_pop     = w_hs && !w_empty;
         default:   ;
      endcase
      busy = (r_state != ST_IDLE) || !w_empty;
   end

   // FIFO storage write.
   // NOTE: the sample array has no reset; stale entries are never read because
   // the count gates every pop, and leaving it unreset lets it map to plain RAM.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.s_feat;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Classifier drive, settle timer and result register.
   // clf_feat only moves on a pop, so the tree input is quiet during settling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clf_feat   <= '0;
         r_settle_cnt <= '0;
         r_m_valid    <= 1'b0;
         r_m_class    <= '0;
         r_m_tag      <= '0;
      end else begin
         if (w_pop) begin
            r_clf_feat   <= r_mem[r_rd_ptr];
            r_settle_cnt <= 8'(SETTLE - 1);
         end else if (r_state == ST_SETTLE && r_settle_cnt != '0) begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
         end
         if (w_capture) begin
            r_m_valid <= 1'b1;
            r_m_class <= clf_class;
         end else if (w_hs) begin
            r_m_valid <= 1'b0;
         end
         if (w_hs) r_m_tag <= r_m_tag + 1'b1;
      end
   end

`ifdef DTREE_HIST_EN
   localparam int N_CLASS = 1 << CLASS_W;

   logic [CNT_W-1:0] r_hist [N_CLASS];

   // Per-class saturating result counters; clear beats a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CLASS; i++) r_hist[i] <= '0;
      end else if (hist_clr) begin
         for (int i = 0; i < N_CLASS; i++) r_hist[i] <= '0;
      end else if (w_hs && r_hist[r_m_class] != '1) begin
         r_hist[r_m_class] <= r_hist[r_m_class] + 1'b1;
      end
   end

   assign hist_count = r_hist[hist_sel];
`else
   logic w_unused_hist;

   assign w_unused_hist = ^{hist_sel, hist_clr};
   assign hist_count    = '0;
`endif
endmodule

// File: tb/tb_dtree_infer_sched.sv
// Self-checking bench for dtree_infer_sched. A transaction-level model (queue
// of buffered samples, an engine countdown and a pending-result slot) predicts
// every output and is compared at each falling edge; directed sections pin
// latency, back-pressure, reset, tag wrap, throughput and the histogram.
module tb_dtree_infer_sched;
   localparam int FEAT_W     = 8;
   localparam int CLASS_W    = 2;
   localparam int SETTLE     = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int TAG_W      = 8;
   localparam int CNT_W      = 4;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst;
   logic [FEAT_W-1:0]  clf_feat;
   logic [CLASS_W-1:0] clf_class;
   logic               busy;
   logic [CLASS_W-1:0] hist_sel;
   logic               hist_clr;
   logic [CNT_W-1:0]   hist_count;

   always #5 clk = ~clk;

   dtree_infer_sched_if #(.FEAT_W(FEAT_W), .CLASS_W(CLASS_W), .TAG_W(TAG_W)) bus ();

   dtree_infer_sched #(
      .FEAT_W(FEAT_W), .CLASS_W(CLASS_W), .SETTLE(SETTLE),
      .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .clf_feat   (clf_feat),
      .clf_class  (clf_class),
      .busy       (busy),
      .hist_sel   (hist_sel),
      .hist_clr   (hist_clr),
      .hist_count (hist_count)
   );

   // Stand-in decision tree: split on bit 5, then on bit 0 or bit 7.
   function automatic logic [1:0] classify(input logic [7:0] f);
      if (f[5]) return f[0] ? 2'd3 : 2'd2;
      return f[7] ? 2'd1 : 2'd0;
   endfunction

   assign clf_class = classify(clf_feat);

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] mq[$];
   bit         eng_has  = 1'b0;
   int         eng_wait = 0;
   logic [7:0] eng_feat = 8'd0;
   bit         res_v    = 1'b0;
   logic [1:0] res_cls  = 2'd0;
   logic [7:0] res_tag  = 8'd0;
   bit         acc_last = 1'b0;
   int         hist_m [4] = '{0, 0, 0, 0};

   initial begin
      int  pre_size;
      bit  acc, hs, free_eng;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            eng_has  = 1'b0;
            eng_wait = 0;
            eng_feat = 8'd0;
            res_v    = 1'b0;
            res_cls  = 2'd0;
            res_tag  = 8'd0;
            acc_last = 1'b0;
            for (int i = 0; i < 4; i++) hist_m[i] = 0;
         end else begin
            pre_size = mq.size();
            acc      = bus.s_valid && (pre_size < FIFO_DEPTH);
            hs       = res_v && bus.m_ready;
            free_eng = (!eng_has && !res_v) || hs;
            if (hist_clr) begin
               for (int i = 0; i < 4; i++) hist_m[i] = 0;
            end else if (hs && hist_m[res_cls] < CNT_MAX) begin
               hist_m[res_cls]++;
            end
            if (eng_has) begin
               eng_wait--;
               if (eng_wait == 0) begin
                  eng_has = 1'b0;
                  res_v   = 1'b1;
                  res_cls = classify(eng_feat);
               end
            end
            if (hs) begin
               res_v   = 1'b0;
               res_tag = res_tag + 8'd1;
            end
            if (free_eng && pre_size > 0) begin
               eng_feat = mq.pop_front();
               eng_has  = 1'b1;
               eng_wait = SETTLE;
            end
            if (acc) mq.push_back(bus.s_feat);
            acc_last = acc;
         end
      end
   end

   // ---------------- cycle compare ----------------
   initial begin
      int exp_hist;
      forever begin
         @(negedge clk);
         if (chk_en) begin
`ifdef DTREE_HIST_EN
            exp_hist = hist_m[hist_sel];
`else
            exp_hist = 0;
`endif
            check("s_ready",    32'(bus.s_ready), (mq.size() < FIFO_DEPTH) ? 1 : 0);
            check("m_valid",    32'(bus.m_valid), 32'(res_v));
            check("m_class",    32'(bus.m_class), 32'(res_cls));
            check("m_tag",      32'(bus.m_tag),   32'(res_tag));
            check("clf_feat",   32'(clf_feat),    32'(eng_feat));
            check("busy",       32'(busy),        (eng_has || res_v || mq.size() > 0) ? 1 : 0);
            check("hist_count", 32'(hist_count),  exp_hist);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "bench time limit");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input logic [7:0] f, input int budget);
      bit done;
      done = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_feat  = f;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         if (acc_last) done = 1'b1;
      end
      bus.s_valid = 1'b0;
      if (!done) check("push timeout", 0, 1);
   endtask

   task automatic wait_valid(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         if (bus.m_valid) done = 1'b1;
      end
      if (!done) check("m_valid timeout", 0, 1);
   endtask

   task automatic drain(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         if (!eng_has && !res_v && mq.size() == 0) done = 1'b1;
      end
      if (!done) check("drain timeout", 0, 1);
   endtask

   // ---------------- directed and random sequences ----------------
   initial begin
      logic [7:0] t2 [6];
      int n_acc, n_got, cyc, last_cyc;

      t2 = '{8'h20, 8'h81, 8'h05, 8'h23, 8'h90, 8'h40};
      rst = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_feat  = '0;
      bus.m_ready = 1'b0;
      hist_sel    = '0;
      hist_clr    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst s_ready",  32'(bus.s_ready), 1);
      check("rst m_valid",  32'(bus.m_valid), 0);
      check("rst m_tag",    32'(bus.m_tag),   0);
      check("rst clf_feat", 32'(clf_feat),    0);
      check("rst busy",     32'(busy),        0);
      @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Single sample: latency and first tag.
      bus.m_ready = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_feat  = 8'd37;
      tick();
      bus.s_valid = 1'b0;
      check("t1 clf_feat before pop", 32'(clf_feat), 0);
      tick();
      check("t1 clf_feat", 32'(clf_feat), 37);
      tick();
      tick();
      check("t1 m_valid early", 32'(bus.m_valid), 0);
      tick();
      check("t1 m_valid", 32'(bus.m_valid), 1);
      check("t1 m_class", 32'(bus.m_class), 3);
      check("t1 m_tag",   32'(bus.m_tag),   0);
      tick();
      check("t1 busy after hs", 32'(busy),        0);
      check("t1 m_tag after",   32'(bus.m_tag),   1);

      // Back-pressure: 6 offered, 5 taken, result held stable.
      apply_reset();
      bus.m_ready = 1'b0;
      n_acc = 0;
      bus.s_valid = 1'b1;
      bus.s_feat  = t2[0];
      for (int i = 0; i < 40 && n_acc < 5; i++) begin
         tick();
         if (acc_last) begin
            n_acc++;
            bus.s_feat = t2[n_acc];
         end
      end
      check("t2 accepted", n_acc, 5);
      check("t2 s_ready full", 32'(bus.s_ready), 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t2 hold s_ready",  32'(bus.s_ready), 0);
         check("t2 hold m_valid",  32'(bus.m_valid), 1);
         check("t2 hold m_class",  32'(bus.m_class), 2);
         check("t2 hold m_tag",    32'(bus.m_tag),   0);
         check("t2 hold clf_feat", 32'(clf_feat),    32'h20);
      end
      bus.m_ready = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 60 && n_acc == 0; i++) begin
         tick();
         if (acc_last) n_acc = 1;
      end
      bus.s_valid = 1'b0;
      check("t2 sixth accepted", n_acc, 1);
      drain(100);
      check("t2 final tag", 32'(bus.m_tag), 6);

      // Reset in mid-settle with three samples queued.
      bus.m_ready = 1'b1;
      bus.s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.s_feat = 8'(8'h10 + i);
         tick();
      end
      bus.s_valid = 1'b0;
      check("t4 busy before rst",    32'(busy),        1);
      check("t4 m_valid before rst", 32'(bus.m_valid), 0);
      rst = 1'b1;
      #1;
      check("t4 rst m_valid",  32'(bus.m_valid), 0);
      check("t4 rst s_ready",  32'(bus.s_ready), 1);
      check("t4 rst busy",     32'(busy),        0);
      check("t4 rst clf_feat", 32'(clf_feat),    0);
      tick();
      rst = 1'b0;
      push(8'h21, 10);
      wait_valid(20);
      check("t4 first tag", 32'(bus.m_tag),   0);
      check("t4 class",     32'(bus.m_class), 3);
      drain(50);

      // 300-sample stream: spacing and tag wrap.
      apply_reset();
      bus.m_ready = 1'b1;
      n_acc = 0;
      n_got = 0;
      cyc = 0;
      last_cyc = 0;
      bus.s_valid = 1'b1;
      bus.s_feat  = 8'($urandom);
      while (n_got < 300 && cyc < 2000) begin
         tick();
         cyc++;
         if (acc_last) begin
            n_acc++;
            if (n_acc >= 300) bus.s_valid = 1'b0;
            else bus.s_feat = 8'($urandom);
         end
         if (bus.m_valid) begin
            check("t5 tag", 32'(bus.m_tag), n_got & 255);
            if (n_got > 0) check("t5 spacing", cyc - last_cyc, SETTLE + 1);
            last_cyc = cyc;
            n_got++;
         end
      end
      check("t5 results", n_got, 300);
      drain(50);

      // Randomised traffic with occasional resets and clears.
      for (int i = 0; i < 1500; i++) begin
         rst         = ($urandom_range(0, 299) == 0);
         bus.s_valid = 1'($urandom_range(0, 1));
         bus.s_feat  = 8'($urandom);
         bus.m_ready = ($urandom_range(0, 9) < 6);
         hist_sel    = 2'($urandom_range(0, 3));
         hist_clr    = ($urandom_range(0, 49) == 0);
         tick();
      end
      rst = 1'b0;
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      hist_clr    = 1'b0;
      drain(100);

`ifdef DTREE_HIST_EN
      // Histogram: saturation, exact counts, clear beating an increment.
      apply_reset();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 20; i++) push(8'h20, 20);
      for (int i = 0; i < 3; i++)  push(8'h80, 20);
      for (int i = 0; i < 2; i++)  push(8'h21, 20);
      drain(200);
      hist_sel = 2'd0; #1; check("hist class0", 32'(hist_count), 0);
      hist_sel = 2'd1; #1; check("hist class1", 32'(hist_count), 3);
      hist_sel = 2'd2; #1; check("hist class2 sat", 32'(hist_count), 15);
      hist_sel = 2'd3; #1; check("hist class3", 32'(hist_count), 2);
      push(8'h80, 20);
      wait_valid(20);
      hist_sel = 2'd1;
      #1;
      check("hist class1 pre-clear", 32'(hist_count), 3);
      hist_clr = 1'b1;
      tick();
      hist_clr = 1'b0;
      for (int s = 0; s < 4; s++) begin
         hist_sel = 2'(s);
         #1;
         check("hist cleared", 32'(hist_count), 0);
      end
`else
      for (int s = 0; s < 4; s++) begin
         hist_sel = 2'(s);
         #1;
         check("hist tied zero", 32'(hist_count), 0);
      end
`endif
      drain(50);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dtree_infer_sched.md
Name: dtree_infer_sched

Overview:
- Sequencing controller in front of the combinational decision-tree classifier (feature in, class out).
- Accepts feature samples over a valid/ready stream and buffers them in a small FIFO.
- Drives one sample at a time onto the classifier input, waits a fixed settle time for the slow printed-logic tree to resolve, then captures the class and presents it on an output valid/ready stream with a sequence tag.

Parameters:
- FEAT_W, 8, width of the feature sample driven to the classifier.
- CLASS_W, 2, width of the classifier class output.
- SETTLE, 3, cycles the classifier input is held stable before the class is sampled; legal range 1..255.
- FIFO_DEPTH, 4, input FIFO depth; power of 2, minimum 2.
- TAG_W, 8, width of the result sequence tag.
- CNT_W, 16, width of each histogram counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input ready; equals !fifo_full.
- s_feat  in  FEAT_W  input feature sample.
- clf_feat  out  FEAT_W  registered feature driven to the classifier.
- clf_class  in  CLASS_W  classifier result (combinational from clf_feat).
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted by downstream.
- m_class  out  CLASS_W  captured class.
- m_tag  out  TAG_W  sequence number of this result.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- hist_sel  in  CLASS_W  histogram class select (optional feature).
- hist_clr  in  1  synchronous histogram clear (optional feature).
- hist_count  out  CNT_W  count for class hist_sel (optional feature).

Behaviour:
- Reset (asynchronous, immediate):
  - FIFO emptied; s_ready=1.
  - clf_feat=0, m_valid=0, m_class=0, m_tag=0, busy=0, hist counters=0.
  - FSM goes to IDLE.
  - Reset mid-operation discards the in-flight sample and all buffered samples.
- FIFO:
  - Push on s_valid&&s_ready.
  - When full, s_ready=0 and there is no pass-through, even if a pop happens in the same cycle.
  - Push and pop in the same cycle (non-full) leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETTLE, OUT.
  - IDLE:
    - FIFO non-empty: pop the head into clf_feat, load settle_cnt=SETTLE-1, go to SETTLE.
    - Otherwise stay; clf_feat holds its last value (never cleared, to limit switching).
  - SETTLE:
    - settle_cnt!=0: decrement.
    - settle_cnt==0: m_class<=clf_class, m_valid<=1, go to OUT.
  - OUT:
    - m_valid, m_class and m_tag are held stable until m_ready is seen.
    - On m_valid&&m_ready: m_valid<=0, m_tag<=m_tag+1 (wraps at 2^TAG_W).
    - If the FIFO is non-empty in that same cycle, pop the next sample into clf_feat and go directly to SETTLE; otherwise go to IDLE.
- Timing:
  - Latency: sample accepted at edge N, clf_feat updated at edge N+1, m_valid rises at edge N+1+SETTLE.
  - Throughput with m_ready held high: one result every SETTLE+1 cycles.
- clf_feat changes only on a pop edge, never while in SETTLE.
- m_tag of the first result after reset is 0.
- busy is registered-state derived (combinational from state and FIFO count) and does not depend on s_valid.

Optional Feature:
- Macro: DTREE_HIST_EN.
- Defined:
  - One CNT_W counter per class (2^CLASS_W counters).
  - The counter for m_class increments on each m_valid&&m_ready handshake.
  - Counters saturate at all-ones and never wrap.
  - hist_clr zeroes all counters on the next edge; it wins over a simultaneous increment.
  - hist_count = counter[hist_sel], combinational read.
- Not defined:
  - No counters are instantiated.
  - hist_count is tied to 0; hist_sel and hist_clr are ignored.
  - Ports stay present so the interface is unchanged.

Test Plan:
- Reset, then one sample s_feat=8'd37, SETTLE=3, m_ready=1 → clf_feat=37 one edge after accept; m_valid high 4 edges after accept with m_class equal to the classifier output for 37, m_tag=0; busy returns to 0 one edge after the handshake.
- Push 6 samples back-to-back with m_ready=0, FIFO_DEPTH=4 → 4 buffered plus 1 in flight; s_ready drops after the 5th accept; the 6th is held until m_ready asserts; results arrive in order with tags 0..5.
- Hold m_ready=0 for 10 cycles while a result is pending → m_valid, m_class and m_tag stable; clf_feat unchanged; no sample popped.
- Assert rst for one cycle in mid-SETTLE with 3 samples queued → immediate m_valid=0, s_ready=1, busy=0; the next accepted sample gets m_tag=0.
- Stream 300 samples with m_ready=1, TAG_W=8 → m_tag wraps 255→0; results spaced exactly SETTLE+1 cycles apart.
- With DTREE_HIST_EN and CNT_W=4: 20 results of class 2 → hist_sel=2 reads 15 (saturated); other classes read their exact counts; hist_clr asserted together with a handshake → all counters read 0 on the following cycle.
